reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16 (power of two, at least 4): number of entries.
REQ-002 SHALL have parameter PREG_W, default $clog2(NUM_PREGS): physical register index width.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-005 alloc_valid  in  1  dispatch presents an instruction; alloc_ready  out  1  entry free.
REQ-006 alloc_pc  in  32; alloc_dst_areg  in  5; alloc_dst_preg  in  PREG_W; alloc_old_preg  in  PREG_W  previous mapping of dst_areg.
REQ-007 alloc_idx  out  $clog2(ROB_DEPTH)  index given to the presented instruction (tail).
REQ-008 ex_valid  in  1; ex_rob_entry_idx  in  $clog2(ROB_DEPTH); ex_val  in  32; br_mispred  in  1; exception  in  1 (execute completion port).
REQ-009 commit_valid  out  1; commit_pc  out  32; commit_dst_areg  out  5; commit_dst_preg, commit_old_preg  out  PREG_W; commit_val  out  32.
REQ-010 flush_valid  out  1; flush_cause  out  1 (0 = mispredict, 1 = exception); flush_pc  out  32.

Function
REQ-011 Storage SHALL be a circular buffer with head/tail pointers of $clog2(ROB_DEPTH)+1 bits; the MSB is the wrap bit.
REQ-012 Empty: pointers equal; full: low bits equal and wrap bits differ.
REQ-013 alloc_ready SHALL equal !full && !flush_valid, from registered state only.
REQ-014 On alloc_valid && alloc_ready: write entry at tail (valid=1, done=0, flags=0), advance tail by 1 at the edge; alloc_idx SHALL always show the low bits of tail.
REQ-015 On ex_valid: if entry[ex_rob_entry_idx].valid, set done=1 and store ex_val, br_mispred and exception; if the entry is invalid, ignore the completion.
REQ-016 The head entry SHALL be committable when valid && done; commit outputs are combinational from head entry state, so the minimum latency from completion to commit is 1 cycle.
REQ-017 Committable head with exception=0 SHALL drive commit_valid=1 and advance head at the edge.
REQ-018 Committable head with br_mispred=1 and exception=0 SHALL drive commit_valid=1, flush_valid=1, flush_cause=0 and flush_pc=head pc in the same cycle.
REQ-019 Committable head with exception=1 SHALL drive commit_valid=0, flush_valid=1, flush_cause=1 and flush_pc=head pc; exception takes priority over br_mispred.
REQ-020 At the edge ending a flush cycle, all valid bits SHALL clear and head and tail SHALL return to 0; any alloc in that cycle is dropped (alloc_ready is already 0).
REQ-021 Simultaneous alloc and commit SHALL both take effect. When full, alloc_ready stays 0 in the commit cycle, since it is not combinationally bypassed from commit.
REQ-022 A completion and a commit on the head in the same cycle: the completion is recorded and the commit uses the pre-edge state.
REQ-023 Pointers SHALL wrap modulo 2*ROB_DEPTH without gaps; at most one alloc, one completion and one commit per cycle.

Reset
REQ-024 While rst=0: head=tail=0 and all valid, done, br_mispred and exception bits clear.
REQ-025 While rst=0: alloc_ready=1, alloc_idx=0, commit_valid=0, flush_valid=0, and all other outputs 0.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously), with no commit or flush emitted.

Structure
REQ-027 ROB_DEPTH default, the rob_entry_t struct (valid, done, pc, dst_areg, dst_preg, old_preg, val, br_mispred, exception) and the flush-cause encoding SHALL live in CORE_PKG.
REQ-028 Pointer/full/empty logic SHALL be the sub-module rob_ptr_ctrl; entry storage and commit/flush decode stay in reorder_buffer.

Verification
REQ-029 Reset; alloc PCs 0x100, 0x104, 0x108 -> alloc_idx 0, 1, 2; completions out of order (2, 0, 1) -> commits in order 0x100, 0x104, 0x108, each no earlier than 1 cycle after the completion that enables it.
REQ-030 Alloc 16 without commit -> alloc_ready=0 after the 16th; complete idx 0 -> commit next cycle; alloc_ready=1 the cycle after; the 17th alloc gets idx 0 (wrap).
REQ-031 Alloc 4; complete idx 1 with br_mispred=1, then idx 0 -> idx 0 commits; idx 1 commits with flush_valid=1, flush_cause=0, flush_pc=0x104; then alloc_idx=0 and buffer empty.
REQ-032 Alloc 2; complete idx 0 with exception=1 and br_mispred=1 -> commit_valid=0, flush_cause=1, flush_pc=0x100, buffer empty next cycle.
REQ-033 Completion to an unallocated idx 5 -> no state change and no commit.
REQ-034 Assert rst=0 mid-stream with 3 entries done -> outputs reset immediately; no commit after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: ROB sizing defaults, the reorder-buffer entry layout
// and the flush-cause encoding.
package core_pkg;

    localparam int ROB_DEPTH_DEF = 16;
    localparam int NUM_PREGS     = 64;
    localparam int PREG_W_DEF    = $clog2(NUM_PREGS);

    typedef enum logic {
        FLUSH_MISPRED   = 1'b0,
        FLUSH_EXCEPTION = 1'b1
    } flush_cause_e;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [31:0]           pc;
        logic [4:0]            dst_areg;
        logic [PREG_W_DEF-1:0] dst_preg;
        logic [PREG_W_DEF-1:0] old_preg;
        logic [31:0]           val;
        logic                  br_mispred;
        logic                  exception;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointer control for the reorder buffer; pointers carry one extra
// wrap bit so full and empty can be told apart without a counter.
module rob_ptr_ctrl #(
    parameter int ROB_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(ROB_DEPTH)-1:0] head_idx,
    output logic [$clog2(ROB_DEPTH)-1:0] tail_idx,
    output logic                         full,
    output logic                         empty
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;

    // Pointer registers; a flush returns both pointers to the origin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
        end else if (flush) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
        end else begin
            if (push) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1);
            end
        end
    end

    assign head_idx = head_r[IDX_W-1:0];
    assign tail_idx = tail_r[IDX_W-1:0];
    assign empty    = (head_r == tail_r);
    assign full     = (head_r[IDX_W-1:0] == tail_r[IDX_W-1:0]) &&
                      (head_r[IDX_W] != tail_r[IDX_W]);

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation, out-of-order completion, in-order commit
// with flush on branch mispredict or exception at the head.
module reorder_buffer
    import core_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [31:0]                  alloc_pc,
    input  logic [4:0]                   alloc_dst_areg,
    input  logic [PREG_W-1:0]            alloc_dst_preg,
    input  logic [PREG_W-1:0]            alloc_old_preg,
    output logic [$clog2(ROB_DEPTH)-1:0] alloc_idx,
    input  logic                         ex_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0] ex_rob_entry_idx,
    input  logic [31:0]                  ex_val,
    input  logic                         br_mispred,
    input  logic                         exception,
    output logic                         commit_valid,
    output logic [31:0]                  commit_pc,
    output logic [4:0]                   commit_dst_areg,
    output logic [PREG_W-1:0]            commit_dst_preg,
    output logic [PREG_W-1:0]            commit_old_preg,
    output logic [31:0]                  commit_val,
    output logic                         flush_valid,
    output logic                         flush_cause,
    output logic [31:0]                  flush_pc
);

    localparam int IDX_W = $clog2(ROB_DEPTH);

    rob_entry_t       rob_r [ROB_DEPTH];
    rob_entry_t       head_entry_s;
    logic [IDX_W-1:0] head_idx_s;
    logic [IDX_W-1:0] tail_idx_s;
    logic             full_s;
    logic             empty_s;
    logic             alloc_fire_s;
    logic             commit_ok_s;
    logic             pop_s;

    rob_ptr_ctrl #(.ROB_DEPTH(ROB_DEPTH)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .push     (alloc_fire_s),
        .pop      (pop_s),
        .flush    (flush_valid),
        .head_idx (head_idx_s),
        .tail_idx (tail_idx_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign head_entry_s = rob_r[head_idx_s];
    assign commit_ok_s  = !empty_s && head_entry_s.valid && head_entry_s.done;
    assign alloc_ready  = !full_s && !flush_valid;
    assign alloc_fire_s = alloc_valid && alloc_ready;
    assign alloc_idx    = tail_idx_s;
    // An excepting head never retires; the flush resets the pointers instead.
    assign pop_s        = commit_ok_s && !head_entry_s.exception;

    // Commit/flush decode from the head entry; exception outranks mispredict.
    always_comb begin
        commit_valid    = 1'b0;
        commit_pc       = 32'h0000_0000;
        commit_dst_areg = 5'h00;
        commit_dst_preg = {PREG_W{1'b0}};
        commit_old_preg = {PREG_W{1'b0}};
        commit_val      = 32'h0000_0000;
        flush_valid     = 1'b0;
        flush_cause     = FLUSH_MISPRED;
        flush_pc        = 32'h0000_0000;
        if (commit_ok_s) begin
            if (head_entry_s.exception) begin
                flush_valid = 1'b1;
                flush_cause = FLUSH_EXCEPTION;
                flush_pc    = head_entry_s.pc;
            end else begin
                commit_valid    = 1'b1;
                commit_pc       = head_entry_s.pc;
                commit_dst_areg = head_entry_s.dst_areg;
                commit_dst_preg = head_entry_s.dst_preg[PREG_W-1:0];
                commit_old_preg = head_entry_s.old_preg[PREG_W-1:0];
                commit_val      = head_entry_s.val;
                if (head_entry_s.br_mispred) begin
                    flush_valid = 1'b1;
                    flush_cause = FLUSH_MISPRED;
                    flush_pc    = head_entry_s.pc;
                end else begin
                    flush_valid = 1'b0;
                end
            end
        end else begin
            commit_valid = 1'b0;
        end
    end

    // Entry storage: allocate at tail, record completions, retire at head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_r[i] <= '0;
            end
        end else if (flush_valid) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_r[i] <= '0;
            end
        end else begin
            if (ex_valid && rob_r[ex_rob_entry_idx].valid) begin
                rob_r[ex_rob_entry_idx].done       <= 1'b1;
                rob_r[ex_rob_entry_idx].val        <= ex_val;
                rob_r[ex_rob_entry_idx].br_mispred <= br_mispred;
                rob_r[ex_rob_entry_idx].exception  <= exception;
            end
            if (alloc_fire_s) begin
                rob_r[tail_idx_s] <= '{valid:      1'b1,
                                       done:       1'b0,
                                       pc:         alloc_pc,
                                       dst_areg:   alloc_dst_areg,
                                       dst_preg:   PREG_W_DEF'(alloc_dst_preg),
                                       old_preg:   PREG_W_DEF'(alloc_old_preg),
                                       val:        32'h0000_0000,
                                       br_mispred: 1'b0,
                                       exception:  1'b0};
            end
            if (pop_s) begin
                rob_r[head_idx_s].valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_pc;
    logic [4:0]  alloc_dst_areg;
    logic [5:0]  alloc_dst_preg;
    logic [5:0]  alloc_old_preg;
    logic [3:0]  alloc_idx;
    logic        ex_valid;
    logic [3:0]  ex_rob_entry_idx;
    logic [31:0] ex_val;
    logic        br_mispred;
    logic        exception;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [4:0]  commit_dst_areg;
    logic [5:0]  commit_dst_preg;
    logic [5:0]  commit_old_preg;
    logic [31:0] commit_val;
    logic        flush_valid;
    logic        flush_cause;
    logic [31:0] flush_pc;

    int n_tests = 0;
    int n_fail  = 0;

    reorder_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_pc         (alloc_pc),
        .alloc_dst_areg   (alloc_dst_areg),
        .alloc_dst_preg   (alloc_dst_preg),
        .alloc_old_preg   (alloc_old_preg),
        .alloc_idx        (alloc_idx),
        .ex_valid         (ex_valid),
        .ex_rob_entry_idx (ex_rob_entry_idx),
        .ex_val           (ex_val),
        .br_mispred       (br_mispred),
        .exception        (exception),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_dst_areg  (commit_dst_areg),
        .commit_dst_preg  (commit_dst_preg),
        .commit_old_preg  (commit_old_preg),
        .commit_val       (commit_val),
        .flush_valid      (flush_valid),
        .flush_cause      (flush_cause),
        .flush_pc         (flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_pc = 32'h0; alloc_dst_areg = 5'h0;
        alloc_dst_preg = 6'h0; alloc_old_preg = 6'h0;
        ex_valid = 1'b0; ex_rob_entry_idx = 4'h0; ex_val = 32'h0;
        br_mispred = 1'b0; exception = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [3:0] exp_idx, input string tag);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_dst_areg = pc[6:2];
        alloc_dst_preg = pc[7:2]; alloc_old_preg = ~pc[7:2];
        settle();
        chk({tag, "_ready"}, {31'h0, alloc_ready}, 32'h1);
        chk({tag, "_idx"}, {28'h0, alloc_idx}, {28'h0, exp_idx});
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic complete(input logic [3:0] idx, input logic [31:0] val,
                            input logic mis, input logic exc);
        ex_valid = 1'b1; ex_rob_entry_idx = idx; ex_val = val;
        br_mispred = mis; exception = exc;
    endtask

    task automatic no_complete();
        ex_valid = 1'b0; br_mispred = 1'b0; exception = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        tick();
        settle();
        chk("rst_ready", {31'h0, alloc_ready}, 32'h1);
        chk("rst_idx", {28'h0, alloc_idx}, 32'h0);
        chk("rst_commit", {31'h0, commit_valid}, 32'h0);
        chk("rst_flush", {31'h0, flush_valid}, 32'h0);
        chk("rst_cpc", commit_pc, 32'h0);
        chk("rst_fpc", flush_pc, 32'h0);
        tick();
        rst = 1'b1;

        // In-order commit of out-of-order completions
        alloc(32'h100, 4'd0, "a0");
        alloc(32'h104, 4'd1, "a1");
        alloc(32'h108, 4'd2, "a2");
        complete(4'd2, 32'hAAA2, 1'b0, 1'b0); settle();
        chk("ooo_c2", {31'h0, commit_valid}, 32'h0);
        tick();
        complete(4'd0, 32'hAAA0, 1'b0, 1'b0); settle();
        chk("ooo_c0_same", {31'h0, commit_valid}, 32'h0);
        tick();
        complete(4'd1, 32'hAAA1, 1'b0, 1'b0); settle();
        chk("ooo_v0", {31'h0, commit_valid}, 32'h1);
        chk("ooo_pc0", commit_pc, 32'h100);
        chk("ooo_val0", commit_val, 32'hAAA0);
        chk("ooo_areg0", {27'h0, commit_dst_areg}, 32'h0);
        tick();
        no_complete(); settle();
        chk("ooo_v1", {31'h0, commit_valid}, 32'h1);
        chk("ooo_pc1", commit_pc, 32'h104);
        chk("ooo_preg1", {26'h0, commit_dst_preg}, 32'h01);
        chk("ooo_old1", {26'h0, commit_old_preg}, 32'h3E);
        tick(); settle();
        chk("ooo_pc2", commit_pc, 32'h108);
        chk("ooo_val2", commit_val, 32'hAAA2);
        chk("ooo_flush2", {31'h0, flush_valid}, 32'h0);
        tick(); settle();
        chk("ooo_empty", {31'h0, commit_valid}, 32'h0);
        chk("ooo_idx3", {28'h0, alloc_idx}, 32'h3);

        // Fill to full, free one slot, wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(32'h1000 + 32'(4 * i), 4'(i), "fill");
        end
        settle();
        chk("full_ready", {31'h0, alloc_ready}, 32'h0);
        complete(4'd0, 32'h55, 1'b0, 1'b0); settle();
        chk("full_nocommit", {31'h0, commit_valid}, 32'h0);
        tick();
        no_complete();
        alloc_valid = 1'b1; alloc_pc = 32'hDEAD; settle();
        chk("full_cv", {31'h0, commit_valid}, 32'h1);
        chk("full_cpc", commit_pc, 32'h1000);
        chk("full_ready_commit", {31'h0, alloc_ready}, 32'h0);
        tick();
        alloc_pc = 32'h200; settle();
        chk("wrap_ready", {31'h0, alloc_ready}, 32'h1);
        chk("wrap_idx", {28'h0, alloc_idx}, 32'h0);
        tick();
        alloc_valid = 1'b0; settle();
        chk("wrap_full", {31'h0, alloc_ready}, 32'h0);
        complete(4'd1, 32'h66, 1'b0, 1'b0);
        tick();
        no_complete(); settle();
        chk("wrap_cpc1", commit_pc, 32'h1004);

        // Branch mispredict flush
        do_reset();
        alloc(32'h100, 4'd0, "m0");
        alloc(32'h104, 4'd1, "m1");
        alloc(32'h108, 4'd2, "m2");
        alloc(32'h10C, 4'd3, "m3");
        complete(4'd1, 32'h11, 1'b1, 1'b0);
        tick();
        complete(4'd0, 32'h10, 1'b0, 1'b0); settle();
        chk("mis_wait", {31'h0, commit_valid}, 32'h0);
        tick();
        no_complete(); settle();
        chk("mis_c0", commit_pc, 32'h100);
        chk("mis_c0_noflush", {31'h0, flush_valid}, 32'h0);
        tick(); settle();
        chk("mis_cv", {31'h0, commit_valid}, 32'h1);
        chk("mis_cpc", commit_pc, 32'h104);
        chk("mis_fv", {31'h0, flush_valid}, 32'h1);
        chk("mis_cause", {31'h0, flush_cause}, 32'h0);
        chk("mis_fpc", flush_pc, 32'h104);
        chk("mis_ready", {31'h0, alloc_ready}, 32'h0);
        tick(); settle();
        chk("mis_idx0", {28'h0, alloc_idx}, 32'h0);
        chk("mis_after_fv", {31'h0, flush_valid}, 32'h0);
        chk("mis_after_ready", {31'h0, alloc_ready}, 32'h1);
        complete(4'd2, 32'h12, 1'b0, 1'b0);
        tick();
        no_complete(); settle();
        chk("mis_dead", {31'h0, commit_valid}, 32'h0);

        // Exception flush, exception outranks mispredict
        do_reset();
        alloc(32'h100, 4'd0, "e0");
        alloc(32'h104, 4'd1, "e1");
        complete(4'd0, 32'h99, 1'b1, 1'b1);
        tick();
        no_complete(); settle();
        chk("exc_cv", {31'h0, commit_valid}, 32'h0);
        chk("exc_fv", {31'h0, flush_valid}, 32'h1);
        chk("exc_cause", {31'h0, flush_cause}, 32'h1);
        chk("exc_fpc", flush_pc, 32'h100);
        tick(); settle();
        chk("exc_idx0", {28'h0, alloc_idx}, 32'h0);
        chk("exc_fv_clr", {31'h0, flush_valid}, 32'h0);
        complete(4'd1, 32'h77, 1'b0, 1'b0);
        tick();
        no_complete(); settle();
        chk("exc_dead", {31'h0, commit_valid}, 32'h0);

        // Completion to an unallocated entry is ignored
        alloc(32'h300, 4'd0, "u0");
        complete(4'd5, 32'hBAD, 1'b1, 1'b1);
        tick();
        no_complete(); settle();
        chk("unal_cv", {31'h0, commit_valid}, 32'h0);
        chk("unal_fv", {31'h0, flush_valid}, 32'h0);
        chk("unal_idx", {28'h0, alloc_idx}, 32'h1);
        complete(4'd0, 32'h333, 1'b0, 1'b0);
        tick();
        no_complete(); settle();
        chk("unal_cpc", commit_pc, 32'h300);
        chk("unal_val", commit_val, 32'h333);
        tick();

        // Asynchronous reset mid-stream
        alloc(32'h400, 4'd1, "r0");
        alloc(32'h404, 4'd2, "r1");
        alloc(32'h408, 4'd3, "r2");
        complete(4'd3, 32'h3, 1'b0, 1'b0); tick();
        complete(4'd2, 32'h2, 1'b0, 1'b0); tick();
        complete(4'd1, 32'h1, 1'b0, 1'b0); tick();
        no_complete(); settle();
        chk("ar_pre_cv", {31'h0, commit_valid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("ar_cv", {31'h0, commit_valid}, 32'h0);
        chk("ar_cpc", commit_pc, 32'h0);
        chk("ar_idx", {28'h0, alloc_idx}, 32'h0);
        chk("ar_ready", {31'h0, alloc_ready}, 32'h1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick(); settle();
        chk("ar_post_cv", {31'h0, commit_valid}, 32'h0);
        chk("ar_post_fv", {31'h0, flush_valid}, 32'h0);
        chk("ar_post_idx", {28'h0, alloc_idx}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
